// File: rtl/oneapi_axi_to_avalon_frame_gasket.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | oneapi_axi_to_avalon_frame_gasket                                           |
// | AXI4-Stream video to Avalon-ST packets: width conversion, EOP policy,       |
// | SOF resync, one-beat hold register and an output FWFT FIFO.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module oneapi_axi_to_avalon_frame_gasket #(
  parameter int PARALLEL_PIXELS      = 1,
  parameter int CHANNELS             = 3,
  parameter int BITS_PER_CHANNEL_AXI = 8,
  parameter int BITS_PER_CHANNEL_AV  = 8,
  parameter int TUSER_BITS           = 3,
  parameter int EMPTY_BITS           = 2,
  parameter int MASK_OUT             = 'hff,
  parameter int FIFO_DEPTH           = 4,
  parameter int EOP_MODE             = 0,
  parameter int FRAME_LINES          = 1080,
  localparam int BITS_AXI = PARALLEL_PIXELS * CHANNELS * BITS_PER_CHANNEL_AXI,
  localparam int BITS_AV  = PARALLEL_PIXELS * CHANNELS * BITS_PER_CHANNEL_AV
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset_n,
  output logic                  axs_tready,
  input  logic                  axs_tvalid,
  input  logic [BITS_AXI-1:0]   axs_tdata,
  input  logic                  axs_tlast,
  input  logic [TUSER_BITS-1:0] axs_tuser,
  input  logic                  aso_ready,
  output logic                  aso_valid,
  output logic [BITS_AV-1:0]    aso_data,
  output logic                  aso_startofpacket,
  output logic                  aso_endofpacket,
  output logic [EMPTY_BITS-1:0] aso_empty,
  output logic                  stat_early_sof,
  output logic                  stat_dropped
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int c_FW = BITS_AV + 2;
  localparam logic [c_LW-1:0] c_LAST_LINE = c_LW'(FRAME_LINES - 1);
  localparam logic [c_AW:0]   c_DEPTH     = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [BITS_PER_CHANNEL_AV-1:0] c_MASK = BITS_PER_CHANNEL_AV'(MASK_OUT);

  localparam logic [0:0] c_WAIT_SOF = 1'b0;
  localparam logic [0:0] c_IN_FRAME = 1'b1;

  logic [0:0]         r_state;
  logic [c_LW-1:0]    r_line_cnt;
  logic               r_expect_sof;
  logic               r_h_valid;
  logic               r_h_sop;
  logic               r_h_eop;
  logic [BITS_AV-1:0] r_h_data;
  logic               r_stat_early;
  logic               r_stat_drop;

  logic [c_FW-1:0]    r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]    r_wptr;
  logic [c_AW-1:0]    r_rptr;
  logic [c_AW:0]      r_count;

  logic [BITS_AV-1:0] w_conv;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic               w_accept;
  logic               w_sof;
  logic               w_drop;
  logic               w_load;
  logic               w_early;
  logic               w_frame_start;
  logic               w_new_sop;
  logic               w_new_eop;
  logic [c_LW-1:0]    w_line_eff;
  logic [c_LW-1:0]    w_line_next;
  logic               w_line_last;
  logic               w_push;
  logic               w_push_eop;
  logic               w_pop;
  logic [c_FW-1:0]    w_head;
  logic               w_unused;

  // Truncate by slicing the input LSBs, widen by zero-extension, then mask.
  for (genvar p = 0; p < PARALLEL_PIXELS; p++) begin : g_pix
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      localparam int c_IDX = p * CHANNELS + c;
      logic [BITS_PER_CHANNEL_AV-1:0] w_ext;
      if (BITS_PER_CHANNEL_AV <= BITS_PER_CHANNEL_AXI) begin : g_trunc
        assign w_ext = axs_tdata[c_IDX*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AV];
      end else begin : g_zext
        assign w_ext = {{(BITS_PER_CHANNEL_AV - BITS_PER_CHANNEL_AXI){1'b0}},
                        axs_tdata[c_IDX*BITS_PER_CHANNEL_AXI +: BITS_PER_CHANNEL_AXI]};
      end
      assign w_conv[c_IDX*BITS_PER_CHANNEL_AV +: BITS_PER_CHANNEL_AV] = w_ext & c_MASK;
    end
  end

  assign w_unused     = ^{axs_tuser, axs_tdata};

  assign w_fifo_full  = (r_count == c_DEPTH);
  assign w_fifo_empty = (r_count == '0);
  assign axs_tready   = !r_h_valid | !w_fifo_full;

  assign w_accept = axs_tvalid & axs_tready;
  assign w_sof    = axs_tuser[0];
  assign w_drop   = w_accept & (r_state == c_WAIT_SOF) & !w_sof;
  assign w_load   = w_accept & !w_drop;
  assign w_early  = w_accept & (r_state == c_IN_FRAME) & w_sof & !r_expect_sof & r_h_valid;

  // A missing SOF after EOP still opens a packet so SOP/EOP always pair.
  assign w_frame_start = (r_state == c_WAIT_SOF) | w_sof;
  assign w_new_sop     = w_frame_start | r_expect_sof;
  assign w_line_eff    = w_frame_start ? '0 : r_line_cnt;
  assign w_line_last   = (w_line_eff == c_LAST_LINE);
  assign w_new_eop     = (EOP_MODE == 1) ? (axs_tlast & w_line_last) : axs_tlast;

  always_comb begin
    w_line_next = w_line_eff;
    if (axs_tlast) begin
      if ((EOP_MODE == 1) && w_line_last) begin
        w_line_next = '0;
      end else begin
        w_line_next = w_line_eff + c_LW'(1);
      end
    end
  end

  // H leaves when displaced by a new beat, or on its own once it carries EOP.
  assign w_push     = r_h_valid & !w_fifo_full & (w_load | r_h_eop);
  assign w_push_eop = r_h_eop | w_early;
  assign w_pop      = !w_fifo_empty & aso_ready;

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_state      <= c_WAIT_SOF;
      r_line_cnt   <= '0;
      r_expect_sof <= 1'b0;
      r_h_valid    <= 1'b0;
      r_h_sop      <= 1'b0;
      r_h_eop      <= 1'b0;
      r_h_data     <= '0;
      r_stat_early <= 1'b0;
      r_stat_drop  <= 1'b0;
    end else begin
      r_stat_early <= w_early;
      r_stat_drop  <= w_drop;
      if (w_load) begin
        r_state      <= c_IN_FRAME;
        r_line_cnt   <= w_line_next;
        r_expect_sof <= w_new_eop;
        r_h_valid    <= 1'b1;
        r_h_sop      <= w_new_sop;
        r_h_eop      <= w_new_eop;
        r_h_data     <= w_conv;
      end else if (w_push) begin
        r_h_valid    <= 1'b0;
      end
    end
  end

  always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
    if (!rsi_reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (c_AW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (c_AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge csi_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {r_h_sop, w_push_eop, r_h_data};
    end
  end

  // Outputs are gated by valid so an empty FIFO presents all-zero sideband.
  assign w_head            = r_mem[r_rptr];
  assign aso_valid         = !w_fifo_empty;
  assign aso_data          = aso_valid ? w_head[BITS_AV-1:0] : '0;
  assign aso_startofpacket = aso_valid & w_head[c_FW-1];
  assign aso_endofpacket   = aso_valid & w_head[c_FW-2];
  assign aso_empty         = '0;
  assign stat_early_sof    = r_stat_early;
  assign stat_dropped      = r_stat_drop;

endmodule
`default_nettype wire

// File: tb/tb_oneapi_axi_to_avalon_frame_gasket.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_oneapi_axi_to_avalon_frame_gasket                                        |
// | Vector table plus directed backpressure and mid-packet reset sequences.    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_oneapi_axi_to_avalon_frame_gasket;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        tvalid;
  logic        tlast;
  logic [2:0]  tuser;
  logic [29:0] tdata;
  logic        aso_ready;

  logic [3:0]  ov, os, oe, otr, ose, osd;
  logic [23:0] d0, d1, d2;
  logic [35:0] d3;
  logic [1:0]  e0, e1, e2, e3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  oneapi_axi_to_avalon_frame_gasket dut0 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .axs_tready(otr[0]), .axs_tvalid(tvalid),
    .axs_tdata(tdata[23:0]), .axs_tlast(tlast), .axs_tuser(tuser), .aso_ready(aso_ready),
    .aso_valid(ov[0]), .aso_data(d0), .aso_startofpacket(os[0]), .aso_endofpacket(oe[0]),
    .aso_empty(e0), .stat_early_sof(ose[0]), .stat_dropped(osd[0]));

  oneapi_axi_to_avalon_frame_gasket #(.EOP_MODE(1), .FRAME_LINES(2)) dut1 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .axs_tready(otr[1]), .axs_tvalid(tvalid),
    .axs_tdata(tdata[23:0]), .axs_tlast(tlast), .axs_tuser(tuser), .aso_ready(aso_ready),
    .aso_valid(ov[1]), .aso_data(d1), .aso_startofpacket(os[1]), .aso_endofpacket(oe[1]),
    .aso_empty(e1), .stat_early_sof(ose[1]), .stat_dropped(osd[1]));

  oneapi_axi_to_avalon_frame_gasket #(.BITS_PER_CHANNEL_AXI(10), .BITS_PER_CHANNEL_AV(8),
                                      .MASK_OUT('hfe)) dut2 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .axs_tready(otr[2]), .axs_tvalid(tvalid),
    .axs_tdata(tdata), .axs_tlast(tlast), .axs_tuser(tuser), .aso_ready(aso_ready),
    .aso_valid(ov[2]), .aso_data(d2), .aso_startofpacket(os[2]), .aso_endofpacket(oe[2]),
    .aso_empty(e2), .stat_early_sof(ose[2]), .stat_dropped(osd[2]));

  oneapi_axi_to_avalon_frame_gasket #(.BITS_PER_CHANNEL_AXI(10), .BITS_PER_CHANNEL_AV(12),
                                      .MASK_OUT('hffe)) dut3 (
    .csi_clk(clk), .rsi_reset_n(rst_n), .axs_tready(otr[3]), .axs_tvalid(tvalid),
    .axs_tdata(tdata), .axs_tlast(tlast), .axs_tuser(tuser), .aso_ready(aso_ready),
    .aso_valid(ov[3]), .aso_data(d3), .aso_startofpacket(os[3]), .aso_endofpacket(oe[3]),
    .aso_empty(e3), .stat_early_sof(ose[3]), .stat_dropped(osd[3]));

  typedef struct {
    int          c;
    logic        sop;
    logic        eop;
    logic [35:0] d;
  } rec_t;

  typedef struct {
    int          grp;
    logic [29:0] d;
    logic        sof;
    logic        last;
    logic        has_out;
    logic [35:0] xd;
    logic        xsop;
    logic        xeop;
  } vec_t;

  rec_t q[$];
  vec_t tbl[$];
  int   sel = 0;
  int   n_drop = 0;
  int   n_early = 0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [35:0] cur_d();
    case (sel)
      0:       return {12'b0, d0};
      1:       return {12'b0, d1};
      2:       return {12'b0, d2};
      default: return d3;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov[sel] && aso_ready) begin
        rec_t r;
        r.c   = cyc;
        r.sop = os[sel];
        r.eop = oe[sel];
        r.d   = cur_d();
        q.push_back(r);
      end
      if (osd[sel]) n_drop++;
      if (ose[sel]) n_early++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 3'b0;
    repeat (2) tick();
    q.delete();
    n_drop  = 0;
    n_early = 0;
    rst_n   = 1'b1;
    tick();
  endtask

  task automatic add(input int g, input logic [29:0] d, input logic sof, input logic last,
                     input logic has, input logic [35:0] xd, input logic xs, input logic xe);
    vec_t v;
    v.grp = g; v.d = d; v.sof = sof; v.last = last;
    v.has_out = has; v.xd = xd; v.xsop = xs; v.xeop = xe;
    tbl.push_back(v);
  endtask

  task automatic run_group(input int g, input int s, input int xdrop, input int xearly);
    int t0;
    int k;
    sel = s;
    aso_ready = 1'b1;
    do_reset();
    t0 = -1;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].grp == g) begin
        if (t0 < 0) t0 = cyc;
        tvalid = 1'b1;
        tdata  = tbl[i].d;
        tuser  = {2'b00, tbl[i].sof};
        tlast  = tbl[i].last;
        tick();
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tuser  = 3'b0;
    repeat (6) tick();
    k = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].grp == g && tbl[i].has_out) begin
        if (k < q.size()) begin
          chk($sformatf("g%0d beat%0d data", g, k), q[k].d, tbl[i].xd);
          chk($sformatf("g%0d beat%0d sop", g, k), q[k].sop, tbl[i].xsop);
          chk($sformatf("g%0d beat%0d eop", g, k), q[k].eop, tbl[i].xeop);
          if (g == 0) chk($sformatf("g0 beat%0d cycle", k), q[k].c, t0 + 2 + k);
        end
        k++;
      end
    end
    chk($sformatf("g%0d beat count", g), q.size(), k);
    chk($sformatf("g%0d dropped pulses", g), n_drop, xdrop);
    chk($sformatf("g%0d early_sof pulses", g), n_early, xearly);
  endtask

  initial begin
    logic w;
    int   acc;
    int   k;

    // group 0: single 3-beat line, EOP per line
    add(0, 30'h112233, 1, 0, 1, 36'h112233, 1, 0);
    add(0, 30'h445566, 0, 0, 1, 36'h445566, 0, 0);
    add(0, 30'h778899, 0, 1, 1, 36'h778899, 0, 1);
    // group 1: EOP per frame of 2 lines, then next SOF line
    add(1, 30'h1, 1, 0, 1, 36'h1, 1, 0);
    add(1, 30'h2, 0, 1, 1, 36'h2, 0, 0);
    add(1, 30'h3, 0, 0, 1, 36'h3, 0, 0);
    add(1, 30'h4, 0, 1, 1, 36'h4, 0, 1);
    add(1, 30'h5, 1, 0, 1, 36'h5, 1, 0);
    add(1, 30'h6, 0, 1, 0, 36'h0, 0, 0);
    // group 2: early SOF on C
    add(2, 30'haaaaaa, 1, 0, 1, 36'haaaaaa, 1, 0);
    add(2, 30'hbbbbbb, 0, 0, 1, 36'hbbbbbb, 0, 1);
    add(2, 30'hcccccc, 1, 0, 1, 36'hcccccc, 1, 0);
    add(2, 30'hdddddd, 0, 1, 1, 36'hdddddd, 0, 1);
    // group 3: beats before the first SOF are dropped
    add(3, 30'h010101, 0, 0, 0, 36'h0, 0, 0);
    add(3, 30'h020202, 0, 1, 0, 36'h0, 0, 0);
    add(3, 30'h0abcde, 1, 1, 1, 36'h0abcde, 1, 1);
    // groups 4/5: 10->8 with mask fe, 10->12 with mask ffe
    add(4, {10'h100, 10'h2a5, 10'h3ff}, 1, 1, 1, 36'h00a4fe, 1, 1);
    add(5, {10'h001, 10'h3ff, 10'h155}, 1, 1, 1, 36'h0003fe154, 1, 1);

    rst_n = 1'b0; tvalid = 1'b0; tlast = 1'b0; tuser = 3'b0; tdata = '0; aso_ready = 1'b1;
    repeat (2) tick();
    chk("reset aso_valid", ov[0], 1'b0);
    chk("reset sop", os[0], 1'b0);
    chk("reset eop", oe[0], 1'b0);
    chk("reset data", d0, 24'h0);
    chk("reset empty", e0, 2'b0);
    chk("reset tready", otr[0], 1'b1);
    chk("reset stat_early", ose[0], 1'b0);
    chk("reset stat_drop", osd[0], 1'b0);
    chk("reset data wide", d3, 36'h0);

    run_group(0, 0, 0, 0);
    run_group(1, 1, 0, 0);
    run_group(2, 0, 0, 1);
    run_group(3, 0, 2, 0);
    run_group(4, 2, 0, 0);
    run_group(5, 3, 0, 0);

    // backpressure: FIFO plus hold register absorb exactly five beats
    sel = 0;
    aso_ready = 1'b1;
    do_reset();
    aso_ready = 1'b0;
    tvalid = 1'b1; tuser = 3'b001; tlast = 1'b0; k = 0; acc = 0; tdata = 30'(k);
    repeat (10) begin
      @(negedge clk);
      w = tvalid & otr[0];
      tick();
      if (w) begin
        acc++;
        k++;
        tdata = 30'(k);
        tuser = 3'b000;
      end
    end
    chk("bp accepted", acc, 5);
    chk("bp tready low", otr[0], 1'b0);
    tvalid = 1'b0;
    aso_ready = 1'b1;
    repeat (8) tick();
    tvalid = 1'b1; tlast = 1'b1;
    tick();
    tvalid = 1'b0; tlast = 1'b0;
    repeat (6) tick();
    chk("bp drain count", q.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < q.size()) begin
        chk($sformatf("bp beat%0d data", i), q[i].d, 36'(i));
        chk($sformatf("bp beat%0d sop", i), q[i].sop, i == 0);
        chk($sformatf("bp beat%0d eop", i), q[i].eop, i == 5);
      end
    end

    // reset with three beats buffered
    do_reset();
    aso_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tvalid = 1'b1;
      tdata  = 30'(33 + i);
      tuser  = {2'b00, (i == 0)};
      tlast  = 1'b0;
      tick();
    end
    tvalid = 1'b0; tuser = 3'b0;
    tick();
    chk("mid-reset valid before", ov[0], 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-reset valid async drop", ov[0], 1'b0);
    repeat (2) tick();
    q.delete();
    n_drop = 0;
    n_early = 0;
    rst_n = 1'b1;
    aso_ready = 1'b1;
    repeat (4) tick();
    chk("mid-reset no stale beats", q.size(), 0);
    tvalid = 1'b1; tdata = 30'h31; tuser = 3'b000; tlast = 1'b0; tick();
    tdata = 30'h32; tlast = 1'b1; tick();
    tdata = 30'h33; tuser = 3'b001; tlast = 1'b1; tick();
    tvalid = 1'b0; tuser = 3'b0; tlast = 1'b0;
    repeat (6) tick();
    chk("mid-reset dropped", n_drop, 2);
    chk("mid-reset beat count", q.size(), 1);
    if (q.size() > 0) begin
      chk("mid-reset data", q[0].d, 36'h33);
      chk("mid-reset sop", q[0].sop, 1'b1);
      chk("mid-reset eop", q[0].eop, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
